// File: rtl/fpga_top_pkg.sv
// Shared constants for the push-button / LED top level.
package fpga_top_pkg;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1250000;
  localparam int unsigned CLK_FREQ_HZ         = 125000000;

  localparam int unsigned LED_FOLLOW = 0;
  localparam int unsigned LED_TOGGLE = 1;

endpackage : fpga_top_pkg

// File: rtl/sig_sync.sv
// Synchronizes an asynchronous level and debounces it: the output only moves
// after the synchronized input has differed from it for DEBOUNCE_CYCLES edges.
module sig_sync
  import fpga_top_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic SYS_CLK,
  input  logic SYS_RST,
  input  logic async_in,
  output logic db_out
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;
  logic                   db_q, db_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // Count consecutive disagreeing cycles; any agreement restarts the count.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync_bit != db_q) begin
      if (cnt_q == CNT_MAX) begin
        db_d = sync_bit;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign db_out = db_q;

endmodule : sig_sync

// File: rtl/fpga_top.sv
// Board top: debounced push-button BTN0 drives LED LD0, either following the
// button level or toggling once per press.
module fpga_top
  import fpga_top_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LED_MODE        = LED_FOLLOW
) (
  input  logic SYS_CLK,
  input  logic SYS_RST,
  input  logic BTN0,
  output logic LD0
);

  logic btn_db;
  logic btn_db_q;
  logic led_q, led_d;

  sig_sync #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync (
    .SYS_CLK  (SYS_CLK),
    .SYS_RST  (SYS_RST),
    .async_in (BTN0),
    .db_out   (btn_db)
  );

  // Toggle mode reacts only to rising edges of the debounced level.
  always_comb begin
    led_d = led_q;
    if (LED_MODE == LED_TOGGLE) begin
      if (btn_db && !btn_db_q) begin
        led_d = ~led_q;
      end
    end else begin
      led_d = btn_db;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      btn_db_q <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      led_q    <= led_d;
    end
  end

  assign LD0 = led_q;

endmodule : fpga_top

// File: tb/tb_fpga_top.sv
// Scoreboard bench: follow-mode and toggle-mode instances share BTN0/SYS_RST;
// a behavioural model predicts LD0 for both every cycle.
module tb_fpga_top;

  localparam int unsigned S = 2;
  localparam int unsigned D = 4;

  logic clk;
  logic SYS_RST;
  logic BTN0;
  logic ld0_follow;
  logic ld0_toggle;

  int checks   = 0;
  int failures = 0;

  fpga_top #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .LED_MODE(0)) dut0 (
    .SYS_CLK (clk),
    .SYS_RST (SYS_RST),
    .BTN0    (BTN0),
    .LD0     (ld0_follow)
  );

  fpga_top #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .LED_MODE(1)) dut1 (
    .SYS_CLK (clk),
    .SYS_RST (SYS_RST),
    .BTN0    (BTN0),
    .LD0     (ld0_toggle)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: a button level is accepted once the synchronized input
  // has disagreed with the accepted level for D consecutive cycles.
  typedef struct packed {
    bit follow;
    bit toggle;
  } exp_t;

  exp_t exp_q[$];
  bit   m_pipe[$];
  bit   m_level, m_level_prev, m_follow, m_toggle;
  int   m_run;

  initial begin
    for (int i = 0; i < int'(S); i++) m_pipe.push_back(1'b0);
    m_level = 0; m_level_prev = 0; m_follow = 0; m_toggle = 0; m_run = 0;
  end

  always @(posedge clk) begin
    exp_t e;
    bit   seen;
    if (SYS_RST) begin
      for (int i = 0; i < int'(S); i++) m_pipe[i] = 1'b0;
      m_level = 0; m_level_prev = 0; m_follow = 0; m_toggle = 0; m_run = 0;
    end else begin
      seen = m_pipe[S-1];
      m_follow = m_level;
      if (m_level && !m_level_prev) m_toggle = !m_toggle;
      m_level_prev = m_level;
      if (seen != m_level) begin
        m_run++;
        if (m_run == int'(D)) begin
          m_level = seen;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      void'(m_pipe.pop_back());
      m_pipe.push_front(BTN0);
    end
    e.follow = m_follow;
    e.toggle = m_toggle;
    exp_q.push_back(e);
  end

  // Monitor: LD0 is presented every cycle; compare against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_ld0_follow", int'(ld0_follow), int'(e.follow));
      check("sb_ld0_toggle", int'(ld0_toggle), int'(e.toggle));
    end
  end

  initial begin
    bit bounce [6];
    bit tog_exp;
    int len;
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    SYS_RST = 1'b1;
    BTN0    = 1'b0;
    tick(2);
    check("reset_ld0_follow", int'(ld0_follow), 0);
    check("reset_ld0_toggle", int'(ld0_toggle), 0);
    check("reset_cnt", int'(dut0.u_sync.cnt_q), 0);
    SYS_RST = 1'b0;
    tick(100);

    // Clean press: LD0 rises 6 edges after the first high sample.
    BTN0 = 1'b1;
    tick(6);
    check("press_edge5_follow", int'(ld0_follow), 0);
    check("press_edge5_toggle", int'(ld0_toggle), 0);
    tick(1);
    check("press_edge6_follow", int'(ld0_follow), 1);
    check("press_edge6_toggle", int'(ld0_toggle), 1);
    tick(10);
    check("steady_follow", int'(ld0_follow), 1);

    // Release, then a 3-cycle glitch that must be rejected.
    BTN0 = 1'b0;
    tick(20);
    check("release_follow", int'(ld0_follow), 0);
    BTN0 = 1'b1;
    tick(3);
    BTN0 = 1'b0;
    tick(10);
    check("glitch_follow", int'(ld0_follow), 0);
    check("glitch_toggle", int'(ld0_toggle), 1);
    check("glitch_cnt", int'(dut0.u_sync.cnt_q), 0);

    // Bouncing press, timed from the last rising sample.
    foreach (bounce[i]) begin
      BTN0 = bounce[i];
      tick(1);
    end
    tick(5);
    check("bounce_edge5_follow", int'(ld0_follow), 0);
    tick(1);
    check("bounce_edge6_follow", int'(ld0_follow), 1);
    check("bounce_edge6_toggle", int'(ld0_toggle), 0);

    // One-cycle reset while the button is held.
    tick(5);
    SYS_RST = 1'b1;
    tick(1);
    SYS_RST = 1'b0;
    check("rst_held_follow", int'(ld0_follow), 0);
    check("rst_held_toggle", int'(ld0_toggle), 0);
    tick(6);
    check("rst_rearm_edge5", int'(ld0_follow), 0);
    tick(1);
    check("rst_rearm_edge6_follow", int'(ld0_follow), 1);
    check("rst_rearm_edge6_toggle", int'(ld0_toggle), 1);

    // Three clean presses in toggle mode from a fresh reset.
    SYS_RST = 1'b1;
    BTN0    = 1'b0;
    tick(2);
    SYS_RST = 1'b0;
    tick(5);
    tog_exp = 1'b0;
    for (int p = 0; p < 3; p++) begin
      BTN0 = 1'b1;
      tick(6);
      check("toggle_before", int'(ld0_toggle), int'(tog_exp));
      tog_exp = !tog_exp;
      tick(1);
      check("toggle_after", int'(ld0_toggle), int'(tog_exp));
      tick(3);
      BTN0 = 1'b0;
      tick(10);
      check("toggle_release_hold", int'(ld0_toggle), int'(tog_exp));
    end

    // Reset mid-count discards the partial count.
    BTN0 = 1'b1;
    tick(4);
    SYS_RST = 1'b1;
    tick(1);
    SYS_RST = 1'b0;
    check("midcount_cnt", int'(dut0.u_sync.cnt_q), 0);
    tick(12);

    // Randomized bouncing with occasional resets.
    for (int i = 0; i < 200; i++) begin
      len  = $urandom_range(1, 8);
      BTN0 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0) begin
        SYS_RST = 1'b1;
        tick(1);
        SYS_RST = 1'b0;
      end
      tick(len);
    end

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fpga_top
